// File: rtl/pmp_access_gate.sv
// pmp_access_gate: serialises core memory requests through a PMP permission
// check. Granted requests are forwarded to memory and the read data is
// returned; denied requests are answered directly with a fault and counted.
// Only one transaction is in flight at a time.
module pmp_access_gate #(
  parameter logic [15:0] FAULT_CNT_MAX = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  // core request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_oper,
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_priv,
  input  logic [31:0] req_wdata,
  // PMP checker
  output logic [31:0] addr,
  output logic [1:0]  oper,
  output logic [1:0]  size,
  output logic [1:0]  priv_mode,
  input  logic [1:0]  permission,
  // memory
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_oper,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  // core response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_fault,
  output logic [3:0]  rsp_cause,
  output logic [31:0] rsp_tval,
  output logic [31:0] rsp_rdata,
  output logic [15:0] fault_count
);

  localparam logic [1:0] OPER_READ  = 2'b00;
  localparam logic [1:0] OPER_WRITE = 2'b01;
  localparam logic [1:0] OPER_EXEC  = 2'b10;
  localparam logic [1:0] OPER_RSVD  = 2'b11;
  localparam logic [1:0] SIZE_RSVD  = 2'b11;
  localparam logic [1:0] PERM_GRANT = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_FWD      = 3'd2,
    ST_WAIT_MEM = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  // Access-fault cause code for a denied operation; reserved opers report as loads.
  function automatic logic [3:0] fault_cause(input logic [1:0] op);
    logic [3:0] cause;
    case (op)
      OPER_EXEC:  cause = 4'd1;
      OPER_READ:  cause = 4'd5;
      OPER_WRITE: cause = 4'd7;
      default:    cause = 4'd5;
    endcase
    return cause;
  endfunction

  state_t      state_r;
  logic        req_ready_r;
  logic [31:0] addr_r;
  logic [1:0]  oper_r;
  logic [1:0]  size_r;
  logic [1:0]  priv_r;
  logic [31:0] wdata_r;
  logic        mem_valid_r;
  logic [31:0] mem_addr_r;
  logic [1:0]  mem_oper_r;
  logic [1:0]  mem_size_r;
  logic [31:0] mem_wdata_r;
  logic        rsp_valid_r;
  logic        rsp_fault_r;
  logic [3:0]  rsp_cause_r;
  logic [31:0] rsp_tval_r;
  logic [31:0] rsp_rdata_r;
  logic [15:0] fault_count_r;
  logic        grant_s;

  // Permission alone is not enough: reserved opers and sizes are always denied.
  assign grant_s = (permission == PERM_GRANT) && (oper_r != OPER_RSVD) &&
                   (size_r != SIZE_RSVD);

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      req_ready_r   <= 1'b0;
      addr_r        <= 32'd0;
      oper_r        <= 2'd0;
      size_r        <= 2'd0;
      priv_r        <= 2'd0;
      wdata_r       <= 32'd0;
      mem_valid_r   <= 1'b0;
      mem_addr_r    <= 32'd0;
      mem_oper_r    <= 2'd0;
      mem_size_r    <= 2'd0;
      mem_wdata_r   <= 32'd0;
      rsp_valid_r   <= 1'b0;
      rsp_fault_r   <= 1'b0;
      rsp_cause_r   <= 4'd0;
      rsp_tval_r    <= 32'd0;
      rsp_rdata_r   <= 32'd0;
      fault_count_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // req_ready comes up one cycle after reset, then stays high while idle
          if (req_ready_r && req_valid) begin
            addr_r      <= req_addr;
            oper_r      <= req_oper;
            size_r      <= req_size;
            priv_r      <= req_priv;
            wdata_r     <= req_wdata;
            req_ready_r <= 1'b0;
            state_r     <= ST_CHECK;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (grant_s) begin
            mem_valid_r <= 1'b1;
            mem_addr_r  <= addr_r;
            mem_oper_r  <= oper_r;
            mem_size_r  <= size_r;
            mem_wdata_r <= wdata_r;
            state_r     <= ST_FWD;
          end else begin
            rsp_valid_r <= 1'b1;
            rsp_fault_r <= 1'b1;
            rsp_cause_r <= fault_cause(oper_r);
            rsp_tval_r  <= addr_r;
            rsp_rdata_r <= 32'd0;
            if (fault_count_r != FAULT_CNT_MAX) begin
              fault_count_r <= fault_count_r + 16'd1;
            end else begin
              fault_count_r <= fault_count_r;
            end
            state_r <= ST_RESP;
          end
        end
        ST_FWD: begin
          if (mem_ready) begin
            mem_valid_r <= 1'b0;
            state_r     <= ST_WAIT_MEM;
          end else begin
            mem_valid_r <= 1'b1;
          end
        end
        ST_WAIT_MEM: begin
          if (mem_rsp_valid) begin
            rsp_valid_r <= 1'b1;
            rsp_fault_r <= 1'b0;
            rsp_cause_r <= 4'd0;
            rsp_tval_r  <= 32'd0;
            rsp_rdata_r <= mem_rdata;
            state_r     <= ST_RESP;
          end else begin
            state_r     <= ST_WAIT_MEM;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          req_ready_r <= 1'b0;
          mem_valid_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_r;
  assign addr        = addr_r;
  assign oper        = oper_r;
  assign size        = size_r;
  assign priv_mode   = priv_r;
  assign mem_valid   = mem_valid_r;
  assign mem_addr    = mem_addr_r;
  assign mem_oper    = mem_oper_r;
  assign mem_size    = mem_size_r;
  assign mem_wdata   = mem_wdata_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_fault   = rsp_fault_r;
  assign rsp_cause   = rsp_cause_r;
  assign rsp_tval    = rsp_tval_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign fault_count = fault_count_r;

endmodule

// File: tb/tb_pmp_access_gate.sv
// Testbench for pmp_access_gate: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_pmp_access_gate;

  localparam logic [15:0] SAT = 16'd40;
  localparam logic [1:0] READ = 2'b00, WRITE = 2'b01, EXEC = 2'b10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [1:0]  req_oper = 2'd0, req_size = 2'd0, req_priv = 2'd0;
  logic [31:0] addr;
  logic [1:0]  oper, size, priv_mode;
  logic [1:0]  permission = 2'd0;
  logic        mem_valid, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_oper, mem_size;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_fault;
  logic [3:0]  rsp_cause;
  logic [31:0] rsp_tval, rsp_rdata;
  logic [15:0] fault_count;

  int checks = 0;
  int failures = 0;
  int mem_hs_cnt = 0;
  int overlap_cnt = 0;
  logic [15:0] fc_model = 16'd0;
  logic [3:0]  cause_tab [4] = '{4'd5, 4'd7, 4'd1, 4'd5};

  logic [193:0] all_out;
  assign all_out = {req_ready, mem_valid, rsp_valid, rsp_fault, rsp_cause, rsp_tval,
                    rsp_rdata, addr, oper, size, priv_mode, mem_addr, mem_oper,
                    mem_size, mem_wdata, fault_count};

  typedef struct {
    bit          timeout;
    int          latency;
    int          mem_hs;
    bit          mem_seen;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_oper, m_size;
    logic [31:0] p_addr;
    logic [1:0]  p_oper, p_size, p_priv;
    bit          pmp_unstable, mem_unstable, rsp_unstable, busy_ready;
    logic        fault;
    logic [3:0]  cause;
    logic [31:0] tval, rdata;
    bit          ready_after;
  } obs_t;

  pmp_access_gate #(.FAULT_CNT_MAX(SAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_oper(req_oper), .req_size(req_size), .req_priv(req_priv), .req_wdata(req_wdata),
    .addr(addr), .oper(oper), .size(size), .priv_mode(priv_mode), .permission(permission),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_oper(mem_oper),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_fault(rsp_fault), .rsp_cause(rsp_cause), .rsp_tval(rsp_tval),
    .rsp_rdata(rsp_rdata), .fault_count(fault_count)
  );

  always #5 clock = ~clock;

  // Count memory handshakes and any cycle with both valids high.
  always @(posedge clock) begin
    if (reset && mem_valid && mem_ready) mem_hs_cnt <= mem_hs_cnt + 1;
    if (mem_valid && rsp_valid) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: grant decision straight from the access rules.
  function automatic bit model_grant(input logic [1:0] perm, input logic [1:0] op,
                                     input logic [1:0] sz);
    return (perm == 2'b01) && (op != 2'b11) && (sz != 2'b11);
  endfunction

  // Drive one full transaction and record what the DUT did.
  task automatic run_txn(input logic [31:0] a, input logic [1:0] op, input logic [1:0] sz,
                         input logic [1:0] pv, input logic [31:0] wd, input logic [1:0] perm,
                         input int mem_wait, input int rsp_delay, input logic [31:0] rd,
                         input int ack_wait, output obs_t o);
    int cyc, mv, post_hs, hs0;
    bit hs_done, rsp_sent;
    o = '{default: 0};
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin @(negedge clock); cyc++; end
    if (req_ready !== 1'b1) begin o.timeout = 1; return; end
    req_valid = 1'b1; req_addr = a; req_oper = op; req_size = sz; req_priv = pv;
    req_wdata = wd; permission = perm; mem_ready = 1'b0; mem_rsp_valid = 1'b0;
    rsp_ready = 1'b0;
    hs0 = mem_hs_cnt;
    @(negedge clock);
    req_valid = 1'b0; req_addr = $urandom; req_oper = 2'($urandom); req_size = 2'($urandom);
    req_priv = 2'($urandom); req_wdata = $urandom;
    o.p_addr = addr; o.p_oper = oper; o.p_size = size; o.p_priv = priv_mode;
    cyc = 1; mv = 0; post_hs = 0; hs_done = 0; rsp_sent = 0;
    while (rsp_valid !== 1'b1 && cyc < 60) begin
      mem_rsp_valid = 1'b0;
      if (req_ready !== 1'b0) o.busy_ready = 1;
      if ({addr, oper, size, priv_mode} !== {o.p_addr, o.p_oper, o.p_size, o.p_priv})
        o.pmp_unstable = 1;
      if (mem_valid === 1'b1) begin
        if (!o.mem_seen) begin
          o.mem_seen = 1; o.m_addr = mem_addr; o.m_oper = mem_oper;
          o.m_size = mem_size; o.m_wdata = mem_wdata;
        end else if ({mem_addr, mem_oper, mem_size, mem_wdata} !==
                     {o.m_addr, o.m_oper, o.m_size, o.m_wdata}) begin
          o.mem_unstable = 1;
        end
        mv++;
        mem_ready = (mv > mem_wait);
        if (!mem_ready && $urandom_range(0, 1) == 1) begin
          mem_rsp_valid = 1'b1; mem_rdata = $urandom;
        end
        if (mem_ready) hs_done = 1;
      end else begin
        mem_ready = 1'b0;
        if (hs_done && !rsp_sent) begin
          if (post_hs >= rsp_delay) begin
            mem_rsp_valid = 1'b1; mem_rdata = rd; rsp_sent = 1;
          end
          post_hs++;
        end
      end
      @(negedge clock);
      cyc++;
    end
    mem_ready = 1'b0; mem_rsp_valid = 1'b0;
    if (rsp_valid !== 1'b1) begin o.timeout = 1; return; end
    o.latency = cyc;
    o.fault = rsp_fault; o.cause = rsp_cause; o.tval = rsp_tval; o.rdata = rsp_rdata;
    for (int k = 0; k < ack_wait; k++) begin
      mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      @(negedge clock);
      if (rsp_valid !== 1'b1 || mem_valid !== 1'b0 ||
          {rsp_fault, rsp_cause, rsp_tval, rsp_rdata} !== {o.fault, o.cause, o.tval, o.rdata})
        o.rsp_unstable = 1;
      if (req_ready !== 1'b0) o.busy_ready = 1;
      if ({addr, oper, size, priv_mode} !== {o.p_addr, o.p_oper, o.p_size, o.p_priv})
        o.pmp_unstable = 1;
    end
    mem_rsp_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    o.ready_after = (req_ready === 1'b1 && rsp_valid === 1'b0);
    o.mem_hs = mem_hs_cnt - hs0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (all_out !== 194'd0) begin
      failures++; $display("FAIL reset_outputs: got %h, expected all zero", all_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready_before_edge: got %b, expected 0", req_ready);
    end
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_rise: got %b, expected 1", req_ready);
    end
  endtask

  task automatic test_grant_load;
    obs_t o;
    run_txn(32'h0000_1000, READ, 2'b10, 2'b11, 32'h1234_5678, 2'b01, 0, 0, 32'hDEAD_BEEF, 0, o);
    checks++;
    if (o.timeout || o.latency != 4) begin
      failures++; $display("FAIL grant_latency: got %0d (timeout %0d), expected 4", o.latency, o.timeout);
    end
    checks++;
    if ({o.fault, o.cause, o.tval, o.rdata} !== {1'b0, 4'd0, 32'd0, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL grant_rsp: got f=%b c=%0d tval=%h rdata=%h, expected 0/0/0/deadbeef",
                           o.fault, o.cause, o.tval, o.rdata);
    end
    checks++;
    if (o.mem_hs != 1 || {o.m_addr, o.m_oper, o.m_size} !== {32'h0000_1000, READ, 2'b10}) begin
      failures++; $display("FAIL grant_mem: got hs=%0d addr=%h op=%b sz=%b, expected 1/00001000/00/10",
                           o.mem_hs, o.m_addr, o.m_oper, o.m_size);
    end
    checks++;
    if ({o.p_addr, o.p_oper, o.p_size, o.p_priv} !== {32'h0000_1000, READ, 2'b10, 2'b11}) begin
      failures++; $display("FAIL grant_pmp_fields: got %h/%b/%b/%b", o.p_addr, o.p_oper, o.p_size, o.p_priv);
    end
    checks++;
    if (fault_count !== fc_model) begin
      failures++; $display("FAIL grant_fault_count: got %0d, expected %0d", fault_count, fc_model);
    end
  endtask

  task automatic test_deny_store;
    obs_t o;
    run_txn(32'h8000_0004, WRITE, 2'b10, 2'b00, 32'hCAFE_0001, 2'b00, 0, 0, 32'h1111_1111, 0, o);
    fc_model = fc_model + 16'd1;
    checks++;
    if (o.timeout || o.latency != 2 || o.mem_seen) begin
      failures++; $display("FAIL deny_store_path: got lat=%0d mem_seen=%0d timeout=%0d, expected 2/0/0",
                           o.latency, o.mem_seen, o.timeout);
    end
    checks++;
    if ({o.fault, o.cause, o.tval, o.rdata} !== {1'b1, 4'd7, 32'h8000_0004, 32'd0}) begin
      failures++; $display("FAIL deny_store_rsp: got f=%b c=%0d tval=%h rdata=%h, expected 1/7/80000004/0",
                           o.fault, o.cause, o.tval, o.rdata);
    end
    checks++;
    if (fault_count !== 16'd1) begin
      failures++; $display("FAIL deny_store_count: got %0d, expected 1", fault_count);
    end
  endtask

  task automatic test_deny_exec_size;
    obs_t o;
    run_txn(32'h0000_4000, EXEC, 2'b11, 2'b00, 32'd0, 2'b01, 0, 0, 32'h2222_2222, 1, o);
    fc_model = fc_model + 16'd1;
    checks++;
    if (o.timeout || o.mem_seen || {o.fault, o.cause, o.tval} !== {1'b1, 4'd1, 32'h0000_4000}) begin
      failures++; $display("FAIL deny_exec_rsp: got f=%b c=%0d tval=%h mem_seen=%0d, expected 1/1/00004000/0",
                           o.fault, o.cause, o.tval, o.mem_seen);
    end
    checks++;
    if (fault_count !== fc_model) begin
      failures++; $display("FAIL deny_exec_count: got %0d, expected %0d", fault_count, fc_model);
    end
  endtask

  task automatic test_backpressure;
    obs_t o;
    run_txn(32'h0000_3008, WRITE, 2'b01, 2'b01, 32'hA5A5_5A5A, 2'b01, 5, 1, 32'h0BAD_F00D, 3, o);
    checks++;
    if (o.timeout || o.latency != 10 || o.mem_hs != 1) begin
      failures++; $display("FAIL bp_latency: got lat=%0d hs=%0d timeout=%0d, expected 10/1/0",
                           o.latency, o.mem_hs, o.timeout);
    end
    checks++;
    if (o.mem_unstable || o.rsp_unstable || o.pmp_unstable || o.busy_ready) begin
      failures++; $display("FAIL bp_stability: got mem=%0d rsp=%0d pmp=%0d ready=%0d, expected all 0",
                           o.mem_unstable, o.rsp_unstable, o.pmp_unstable, o.busy_ready);
    end
    checks++;
    if ({o.m_addr, o.m_wdata, o.fault, o.rdata} !== {32'h0000_3008, 32'hA5A5_5A5A, 1'b0, 32'h0BAD_F00D}) begin
      failures++; $display("FAIL bp_data: got addr=%h wdata=%h f=%b rdata=%h", o.m_addr, o.m_wdata, o.fault, o.rdata);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      run_txn(32'h100 * i, READ, 2'b00, 2'b00, 32'd0, (i % 2 == 0) ? 2'b10 : 2'b01, 0, 0,
              32'h5000 + i, 0, o);
      if (i % 2 == 0) fc_model = fc_model + 16'd1;
      checks++;
      if (!o.ready_after || o.timeout || o.latency != ((i % 2 == 0) ? 2 : 4)) begin
        failures++; $display("FAIL b2b_%0d: got ready_after=%0d lat=%0d timeout=%0d",
                             i, o.ready_after, o.latency, o.timeout);
      end
    end
  endtask

  task automatic test_random;
    obs_t o;
    logic [31:0] a, wd, rd;
    logic [1:0]  op, sz, pv, perm;
    int mw, dly, ack, exp_lat;
    bit g;
    for (int i = 0; i < 150; i++) begin
      a = $urandom; wd = $urandom; rd = $urandom;
      op = 2'($urandom); sz = 2'($urandom); pv = 2'($urandom);
      perm = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b01;
      mw = $urandom_range(0, 3); dly = $urandom_range(0, 2); ack = $urandom_range(0, 2);
      run_txn(a, op, sz, pv, wd, perm, mw, dly, rd, ack, o);
      g = model_grant(perm, op, sz);
      exp_lat = g ? 4 + mw + dly : 2;
      if (!g && fc_model != SAT) fc_model = fc_model + 16'd1;
      checks++;
      if (o.timeout || o.latency != exp_lat || o.mem_hs != (g ? 1 : 0)) begin
        failures++; $display("FAIL rand_%0d_flow: got lat=%0d hs=%0d to=%0d, expected lat=%0d hs=%0d",
                             i, o.latency, o.mem_hs, o.timeout, exp_lat, g ? 1 : 0);
      end
      checks++;
      if ({o.fault, o.cause, o.tval, o.rdata} !==
          (g ? {1'b0, 4'd0, 32'd0, rd} : {1'b1, cause_tab[op], a, 32'd0})) begin
        failures++; $display("FAIL rand_%0d_rsp: got f=%b c=%0d tval=%h rdata=%h (op=%b sz=%b perm=%b)",
                             i, o.fault, o.cause, o.tval, o.rdata, op, sz, perm);
      end
      checks++;
      if ({o.p_addr, o.p_oper, o.p_size, o.p_priv} !== {a, op, sz, pv} ||
          (g && {o.m_addr, o.m_oper, o.m_size, o.m_wdata} !== {a, op, sz, wd})) begin
        failures++; $display("FAIL rand_%0d_fields: got pmp=%h/%b/%b/%b mem=%h/%b/%b/%h",
                             i, o.p_addr, o.p_oper, o.p_size, o.p_priv,
                             o.m_addr, o.m_oper, o.m_size, o.m_wdata);
      end
      checks++;
      if (o.pmp_unstable || o.mem_unstable || o.rsp_unstable || o.busy_ready || !o.ready_after) begin
        failures++; $display("FAIL rand_%0d_hold: got pmp=%0d mem=%0d rsp=%0d busy=%0d after=%0d",
                             i, o.pmp_unstable, o.mem_unstable, o.rsp_unstable, o.busy_ready, o.ready_after);
      end
      checks++;
      if (fault_count !== fc_model) begin
        failures++; $display("FAIL rand_%0d_count: got %0d, expected %0d", i, fault_count, fc_model);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    obs_t o;
    int n;
    bit seen;
    req_valid = 1'b1; req_addr = 32'h0000_2000; req_oper = READ; req_size = 2'b10;
    req_priv = 2'b11; req_wdata = 32'd0; permission = 2'b01;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (mem_valid !== 1'b1 && n < 10) begin @(negedge clock); n++; end
    checks++;
    if (mem_valid !== 1'b1) begin
      failures++; $display("FAIL rst_mid_fwd: got mem_valid=%b, expected 1", mem_valid);
    end
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (all_out !== 194'd0) begin
      failures++; $display("FAIL rst_mid_async: got %h, expected all zero", all_out);
    end
    mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    repeat (2) @(negedge clock);
    checks++;
    if (all_out !== 194'd0) begin
      failures++; $display("FAIL rst_mid_hold: got %h, expected all zero", all_out);
    end
    reset = 1'b1;
    fc_model = 16'd0;
    seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) seen = 1;
    end
    mem_rsp_valid = 1'b0;
    checks++;
    if (seen) begin
      failures++; $display("FAIL rst_mid_stale_rsp: got a response after reset, expected none");
    end
    run_txn(32'h0000_2040, READ, 2'b10, 2'b00, 32'd0, 2'b01, 0, 0, 32'h7777_0001, 0, o);
    checks++;
    if (o.timeout || {o.fault, o.rdata} !== {1'b0, 32'h7777_0001} || fault_count !== 16'd0) begin
      failures++; $display("FAIL rst_mid_next: got to=%0d f=%b rdata=%h count=%0d, expected 0/0/77770001/0",
                           o.timeout, o.fault, o.rdata, fault_count);
    end
  endtask

  task automatic test_saturation;
    obs_t o;
    for (int i = 0; i < int'(SAT) + 3; i++) begin
      run_txn($urandom, WRITE, 2'b10, 2'b00, 32'd0, 2'b00, 0, 0, 32'd0, 0, o);
      if (fc_model != SAT) fc_model = fc_model + 16'd1;
      if (i >= int'(SAT) - 2) begin
        checks++;
        if (fault_count !== fc_model) begin
          failures++; $display("FAIL sat_%0d: got %0d, expected %0d", i, fault_count, fc_model);
        end
      end
    end
    checks++;
    if (fault_count !== SAT) begin
      failures++; $display("FAIL sat_final: got %0d, expected %0d", fault_count, SAT);
    end
  endtask

  task automatic test_exclusive_valids;
    checks++;
    if (overlap_cnt != 0) begin
      failures++; $display("FAIL valid_overlap: got %0d cycles, expected 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_grant_load();
    test_deny_store();
    test_deny_exec_size();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    test_saturation();
    test_exclusive_valids();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmp_access_gate.md
PMP_ACCESS_GATE -- requirements
Module: pmp_access_gate

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req_valid/req_ready  input/output  1/1  core request handshake.
REQ-004 SHALL have ports: req_addr  input  32; req_oper  input  2 (cep_define READ/WRITE/EXECUTE; 2'b11 reserved); req_size  input  2 (00 byte, 01 half, 10 word, 11 reserved); req_priv  input  2; req_wdata  input  32.
REQ-005 SHALL have ports to PMP checker: addr  output  32; oper  output  2; size  output  2; priv_mode  output  2; permission  input  2 (2'b01 grant; any other value deny).
REQ-006 SHALL have ports to memory: mem_valid  output  1; mem_ready  input  1; mem_addr  output  32; mem_oper  output  2; mem_size  output  2; mem_wdata  output  32; mem_rsp_valid  input  1; mem_rdata  input  32.
REQ-007 SHALL have ports to core: rsp_valid  output  1; rsp_ready  input  1; rsp_fault  output  1; rsp_cause  output  4; rsp_tval  output  32; rsp_rdata  output  32.
REQ-008 SHALL have port: fault_count  output  16  saturating count of denied accesses.

Function
REQ-009 SHALL implement FSM states IDLE, CHECK, FWD, WAIT_MEM, RESP.
REQ-010 IDLE: req_ready=1; on req_valid latch addr/oper/size/priv/wdata into registers -> CHECK; otherwise remain in IDLE.
REQ-011 PMP outputs addr/oper/size/priv_mode SHALL be driven from the latched registers only, stable from CHECK through RESP.
REQ-012 CHECK SHALL last exactly one cycle; sample permission at its end.
REQ-013 Grant condition: permission==2'b01 AND oper!=2'b11 AND size!=2'b11; granted -> FWD; otherwise -> RESP with fault.
REQ-014 Fault cause: EXECUTE=4'd1, READ=4'd5, WRITE=4'd7, reserved oper=4'd5; rsp_tval=latched addr; rsp_rdata=0.
REQ-015 FWD: mem_valid=1 with latched fields; hold until mem_ready=1 -> WAIT_MEM; mem_valid deasserts the next cycle.
REQ-016 WAIT_MEM: on mem_rsp_valid capture mem_rdata into rsp_rdata, rsp_fault=0, rsp_cause=0, rsp_tval=0 -> RESP; mem_rsp_valid outside WAIT_MEM SHALL be ignored.
REQ-017 RESP: rsp_valid=1, all rsp_* stable until rsp_ready=1 -> IDLE; req_ready SHALL be 0 in every state except IDLE.
REQ-018 Minimum request-to-response latency: granted path 4 cycles (IDLE, CHECK, FWD, WAIT_MEM with immediate ready/rsp); denied path 2 cycles (rsp_valid asserted in cycle after CHECK).
REQ-019 Back-to-back: request accepted in the IDLE cycle after RESP handshake; no overlap of transactions.
REQ-020 fault_count SHALL increment by 1 on every CHECK->RESP fault transition, saturating at 16'hFFFF.
REQ-021 mem_valid and rsp_valid SHALL never be asserted in the same cycle.

Reset
REQ-022 While reset=0: state=IDLE, req_ready=0, mem_valid=0, rsp_valid=0, rsp_fault=0, rsp_cause=0, rsp_tval=0, rsp_rdata=0, addr/oper/size/priv_mode=0, mem_* outputs=0, fault_count=0.
REQ-023 req_ready SHALL rise in the first cycle after reset deasserts.
REQ-024 Reset asserted in any state SHALL abort the transaction immediately; no response is ever issued for the aborted request.

Verification
REQ-025 Grant load: req addr=32'h0000_1000, oper=READ, size=10, permission=01, mem_ready=1, mem_rsp_valid next cycle with mem_rdata=32'hDEADBEEF -> rsp_valid, rsp_fault=0, rsp_rdata=32'hDEADBEEF, fault_count=0.
REQ-026 Deny store: oper=WRITE, addr=32'h8000_0004, permission=00 -> no mem_valid, rsp_fault=1, rsp_cause=7, rsp_tval=32'h8000_0004, fault_count=1.
REQ-027 Deny execute with reserved size: oper=EXECUTE, size=11, permission=01 -> rsp_fault=1, rsp_cause=1.
REQ-028 Backpressure: mem_ready low 5 cycles, then rsp_ready low 3 cycles -> mem_* and rsp_* stable throughout, req_ready=0, single mem_valid handshake.
REQ-029 Reset mid-WAIT_MEM: reset low for 2 cycles -> all outputs at reset values, later mem_rsp_valid ignored, next request completes normally.
REQ-030 Saturation: force 65537 denied requests -> fault_count holds 16'hFFFF.
